// File: rtl/capture_readout_controller.sv
// Capture readout: holds acquisition, streams a frame from sample memory via a 2-entry FIFO.
// Optional READOUT_DECIMATE_EN adds decim_shift[2:0] (step = 2^decim_shift, sampled in HOLD).
module capture_readout_controller #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 51200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture_done,
`ifdef READOUT_DECIMATE_EN
    input  logic [2:0]        decim_shift,
`endif
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              hold_capture_n,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_READ,
        S_DRAIN,
        S_RELEASE
    } state_t;

    localparam int CW = ADDR_W + 8;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     infl_q, infl_d;
    logic                     infl_first_q, infl_first_d;
    logic                     infl_last_q, infl_last_d;
    logic [1:0][DATA_W-1:0]   data_q, data_d;
    logic [1:0]               first_q, first_d;
    logic [1:0]               last_q, last_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               count_q, count_d;

    logic [CW-1:0]            step;
    logic [CW-1:0]            next_addr;
    logic                     last_rd;
    logic [1:0]               occ;
    logic                     rd_fire;
    logic                     fifo_has;
    logic [DATA_W-1:0]        head_data;
    logic                     head_first;
    logic                     head_last;
    logic                     push;
    logic                     pop;

`ifdef READOUT_DECIMATE_EN
    logic [2:0]               shift_q, shift_d;

    assign step = CW'(1) << shift_q;
`else
    assign step = CW'(1);
`endif

    assign next_addr = CW'(addr_q) + step;
    assign last_rd   = next_addr >= DEPTH_W;

    // Occupancy counts in-flight reads so the FIFO can never overflow.
    assign occ      = count_q + {1'b0, infl_q};
    assign rd_fire  = (state_q == S_READ) && (occ < 2'd2);
    assign fifo_has = (count_q != 2'd0);

    // Fall-through head: an empty FIFO presents the returning read directly.
    always_comb begin
        head_data  = mem_rdata;
        head_first = infl_first_q;
        head_last  = infl_last_q;
        if (fifo_has) begin
            head_data  = data_q[rd_ptr_q];
            head_first = first_q[rd_ptr_q];
            head_last  = last_q[rd_ptr_q];
        end
    end

    assign sample_valid = fifo_has | infl_q;
    assign sample_data  = sample_valid ? head_data : '0;
    assign frame_start  = sample_valid & head_first;
    assign frame_end    = sample_valid & head_last;

    assign pop  = fifo_has & sample_ready;
    assign push = infl_q & ~(~fifo_has & sample_ready);

    assign mem_rd_en      = rd_fire;
    assign mem_raddr      = addr_q;
    assign busy           = (state_q != S_IDLE);
    assign hold_capture_n = ~((state_q == S_HOLD) |
                              (state_q == S_READ) |
                              (state_q == S_DRAIN));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
`ifdef READOUT_DECIMATE_EN
        shift_d = shift_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (capture_done) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                addr_d  = '0;
                state_d = S_READ;
`ifdef READOUT_DECIMATE_EN
                shift_d = decim_shift;
`endif
            end
            S_READ: begin
                if (rd_fire) begin
                    if (last_rd) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = next_addr[ADDR_W-1:0];
                    end
                end
            end
            S_DRAIN: begin
                if (!fifo_has && !infl_q) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        infl_d       = rd_fire;
        infl_first_d = rd_fire && (addr_q == '0);
        infl_last_d  = rd_fire && last_rd;
        data_d       = data_q;
        first_d      = first_q;
        last_d       = last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (push) begin
            data_d[wr_ptr_q]  = mem_rdata;
            first_d[wr_ptr_q] = infl_first_q;
            last_d[wr_ptr_q]  = infl_last_q;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            infl_q       <= 1'b0;
            infl_first_q <= 1'b0;
            infl_last_q  <= 1'b0;
            data_q       <= '0;
            first_q      <= '0;
            last_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
`ifdef READOUT_DECIMATE_EN
            shift_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            infl_q       <= infl_d;
            infl_first_q <= infl_first_d;
            infl_last_q  <= infl_last_d;
            data_q       <= data_d;
            first_q      <= first_d;
            last_q       <= last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
`ifdef READOUT_DECIMATE_EN
            shift_q      <= shift_d;
`endif
        end
    end

endmodule

// File: tb/tb_capture_readout_controller.sv
// Randomized bench for capture_readout_controller against a frame-level model.
// With READOUT_DECIMATE_EN defined it uses DEPTH=10 and varies the step.
module tb_capture_readout_controller;

    localparam int DW = 12;
    localparam int AW = 17;
`ifdef READOUT_DECIMATE_EN
    localparam int DEPTH = 10;
`else
    localparam int DEPTH = 8;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          capture_done = 1'b0;
    logic          sample_ready = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata = '0;
    logic          hold_capture_n;
    logic [DW-1:0] sample_data;
    logic          sample_valid;
    logic          frame_start;
    logic          frame_end;
    logic          busy;
`ifdef READOUT_DECIMATE_EN
    logic [2:0]    decim_shift = '0;
`endif

    capture_readout_controller #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .capture_done  (capture_done),
`ifdef READOUT_DECIMATE_EN
        .decim_shift   (decim_shift),
`endif
        .mem_rd_en     (mem_rd_en),
        .mem_raddr     (mem_raddr),
        .mem_rdata     (mem_rdata),
        .hold_capture_n(hold_capture_n),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];

    // Synchronous memory: data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            if (int'(mem_raddr) < DEPTH) mem_rdata <= mem[int'(mem_raddr)];
            else mem_rdata <= 'x;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, "_raddr"}, 32'(mem_raddr), 0);
        check({tag, "_valid"}, 32'(sample_valid), 0);
        check({tag, "_data"}, 32'(sample_data), 0);
        check({tag, "_fstart"}, 32'(frame_start), 0);
        check({tag, "_fend"}, 32'(frame_end), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_hold_n"}, 32'(hold_capture_n), 1);
    endtask

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
        bit            first;
        bit            last;
    } beat_t;

    // mode 0: ready=1, 1: ready 1,0,0,1 repeating, 2: random ready
    task automatic run_frame(input int mode, input bit dup, input int rst_beat,
                             input int shift);
        beat_t         exp_q[$];
        beat_t         b;
        int            step;
        int            reads;
        int            beats;
        int            first_cyc;
        int            total;
        bit            done;
        bit            pv;
        bit            pr;
        logic [DW-1:0] pd;
        step = 1 << shift;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int a = 0; a < DEPTH; a += step) begin
            b.addr  = a;
            b.data  = mem[a];
            b.first = (a == 0);
            b.last  = (a + step >= DEPTH);
            exp_q.push_back(b);
        end
        total = exp_q.size();
        reads = 0;
        beats = 0;
        first_cyc = -1;
        done = 1'b0;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            capture_done = (cyc == 0) || (dup && cyc == 5);
            case (mode)
                0: sample_ready = 1'b1;
                1: sample_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: sample_ready = 1'($urandom_range(0, 1));
            endcase
`ifdef READOUT_DECIMATE_EN
            decim_shift = (cyc < 3) ? 3'(shift) : 3'($urandom_range(0, 7));
`endif
            #1;
            if (cyc == 0) check("idle_busy", 32'(busy), 0);
            if (cyc == 1) begin
                check("hold_busy", 32'(busy), 1);
                check("hold_n_low", 32'(hold_capture_n), 0);
            end
            if (pv && !pr) begin
                check("stall_valid", 32'(sample_valid), 1);
                check("stall_data", 32'(sample_data), 32'(pd));
            end
            if (sample_valid && first_cyc < 0) begin
                first_cyc = cyc;
                check("latency", cyc, 3);
            end
            if (mem_rd_en) begin
                check("raddr", 32'(mem_raddr), reads * step);
                reads++;
                check("outstanding", 32'(reads - beats <= 2), 1);
            end
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", 32'(sample_data), 32'(b.data));
                    check("beat_start", 32'(frame_start), 32'(b.first));
                    check("beat_end", 32'(frame_end), 32'(b.last));
                    check("beat_hold_n", 32'(hold_capture_n), 0);
                    if (mode == 0) check("beat_cycle", cyc, 3 + beats);
                end
                beats++;
                if (rst_beat >= 0 && beats == rst_beat + 1) begin
                    @(negedge clk);
                    capture_done = 1'b0;
                    reset_n = 1'b0;
                    #1;
                    check_reset_outputs("midrst");
                    @(negedge clk);
                    reset_n = 1'b1;
                    return;
                end
            end
            pv = sample_valid;
            pr = sample_ready;
            pd = sample_data;
            if (beats == total && !busy && cyc > 0) done = 1'b1;
        end
        capture_done = 1'b0;
        if (!done) check("timeout", 0, 1);
        check("beat_count", beats, total);
        check("end_hold_n", 32'(hold_capture_n), 1);
        if (dup) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                #1;
                check("noqueue_busy", 32'(busy), 0);
                check("noqueue_valid", 32'(sample_valid), 0);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(0, 1'b0, -1, 0);
        run_frame(1, 1'b0, -1, 0);
        run_frame(0, 1'b1, -1, 0);
        run_frame(0, 1'b0, 3, 0);
        run_frame(0, 1'b0, -1, 0);
`ifdef READOUT_DECIMATE_EN
        run_frame(0, 1'b0, -1, 2);
        run_frame(1, 1'b0, -1, 2);
        for (int f = 0; f < 6; f++) begin
            run_frame(2, 1'($urandom_range(0, 1)), -1, $urandom_range(0, 4));
        end
`else
        for (int f = 0; f < 6; f++) begin
            run_frame(2, 1'($urandom_range(0, 1)), -1, 0);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/capture_readout_controller.md
CAPTURE_READOUT_CONTROLLER -- requirements
Module: capture_readout_controller

Interface
REQ-001 Parameter DATA_W, default 12, sample width in bits.
REQ-002 Parameter ADDR_W, default 17, sample memory address width.
REQ-003 Parameter DEPTH, default 51200, number of samples per captured frame.
REQ-004 clk  input  1  single block clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 capture_done  input  1  one-cycle pulse from the acquisition side: memory holds a complete frame starting at address 0.
REQ-007 mem_rd_en  output  1  sample memory read strobe.
REQ-008 mem_raddr  output  ADDR_W  sample memory read address.
REQ-009 mem_rdata  input  DATA_W  read data, valid exactly one cycle after the mem_rd_en cycle.
REQ-010 hold_capture_n  output  1  low = acquisition must not write memory.
REQ-011 sample_data  output  DATA_W  outgoing sample.
REQ-012 sample_valid  output  1  sample_data is valid.
REQ-013 sample_ready  input  1  consumer accepts; a beat transfers when valid and ready are both high.
REQ-014 frame_start  output  1  high with the beat carrying address 0.
REQ-015 frame_end  output  1  high with the final beat of the frame.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, HOLD, READ, DRAIN and RELEASE.
REQ-018 IDLE: capture_done=1 -> HOLD; otherwise remain in IDLE.
REQ-019 HOLD: drive hold_capture_n low; go to READ after exactly one cycle. The address counter is cleared to 0.
REQ-020 READ: issue a read when (buffered entries + in-flight reads) < 2; each read increments the address by the step (REQ-031). After the read of the last address, go to DRAIN.
REQ-021 DRAIN: issue no reads; go to RELEASE when the buffer is empty and no read is in flight.
REQ-022 RELEASE: hold_capture_n high for one cycle, then go to IDLE.
REQ-023 hold_capture_n SHALL be low in HOLD, READ and DRAIN, and high in IDLE and RELEASE.
REQ-024 Read data SHALL enter a 2-entry FIFO. sample_data/sample_valid SHALL come from the FIFO head. No beat is dropped or duplicated under any sample_ready pattern.
REQ-025 sample_valid, once high, SHALL stay high with sample_data stable until the beat transfers.
REQ-026 Latency: with sample_ready held high, the first beat SHALL be valid 3 cycles after the capture_done cycle (HOLD, read, data). Throughput is then one beat per cycle.
REQ-027 Total beats per frame: exactly ceil(DEPTH/step). The last read address SHALL be the largest multiple of step that is <= DEPTH-1, and the address SHALL never reach DEPTH.
REQ-028 capture_done while busy SHALL be ignored; it is not queued.
REQ-029 sample_ready low for any duration SHALL stall reads without losing data; the state SHALL remain READ or DRAIN.

Reset
REQ-030 reset_n low, at any time including mid-frame, SHALL immediately force:
  - state IDLE, FIFO empty, in-flight read cleared, address 0;
  - mem_rd_en=0, mem_raddr=0, sample_valid=0, sample_data=0, frame_start=0, frame_end=0, busy=0, hold_capture_n=1.

Configuration
REQ-031 Macro READOUT_DECIMATE_EN:
  - Defined: add input decim_shift[2:0]. It is sampled in HOLD and the step is 2^decim_shift for the whole frame.
  - Not defined: the port is absent and the step is 1.

Verification
REQ-032 DEPTH=8, ready=1, capture_done pulse -> 8 beats with data = mem[0..7] on consecutive cycles; first beat 3 cycles after the pulse; frame_start on beat 0; frame_end on beat 7; hold_capture_n low from HOLD through DRAIN.
REQ-033 DEPTH=8, sample_ready toggling 1,0,0,1 repeating -> all 8 beats delivered in order; no more than 2 reads outstanding; sample_data stable while stalled.
REQ-034 Second capture_done while a frame is being read -> ignored; exactly one frame is output; busy returns low after RELEASE.
REQ-035 reset_n asserted after beat 3 -> all outputs at reset values in the same cycle; a new capture_done then produces a full frame starting at address 0.
REQ-036 READOUT_DECIMATE_EN defined, DEPTH=10, decim_shift=2 -> reads at addresses 0, 4, 8; 3 beats; frame_end on the beat from address 8.
